// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: a DEPTH-entry circular FIFO of {pc, inst}
// with branch flush (optionally keeping one delay-slot entry). Optional macro:
// ID_INST_QUEUE_BYPASS_EN lets an empty queue pass IF straight through to ID.
module id_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_inst,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_inst,
   input  logic                     out_ready,
   input  logic                     flush,
   input  logic                     flush_keep,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]   r_mem_pc   [DEPTH];
   logic [INST_W-1:0] r_mem_inst [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;

   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic              w_bypass_take;
   logic [AW-1:0]     w_rd_next;
   logic [CW-1:0]     w_left;

   always_comb begin
      w_empty       = (r_count == '0);
`ifdef ID_INST_QUEUE_BYPASS_EN
      // An empty queue forwards IF directly; if ID takes it, nothing is stored.
      out_valid     = w_empty && !flush ? in_valid : !w_empty;
      out_pc        = w_empty && !flush ? in_pc    : r_mem_pc[r_rd_ptr];
      out_inst      = w_empty && !flush ? in_inst  : r_mem_inst[r_rd_ptr];
      w_bypass_take = w_empty & ~flush & in_valid & out_ready;
`else
      out_valid     = !w_empty;
      out_pc        = r_mem_pc[r_rd_ptr];
      out_inst      = r_mem_inst[r_rd_ptr];
      w_bypass_take = 1'b0;
`endif
      w_pop     = !w_empty & out_ready;
      in_ready  = (r_count < CW'(DEPTH)) | w_pop;
      w_push    = in_valid & in_ready & ~flush & ~w_bypass_take;
      w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      w_left    = r_count - CW'(w_pop);
   end

   // Flush is resolved against the post-pop state; a kept entry is the new head.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= w_rd_next;
         if (flush) begin
            if (flush_keep && w_left != '0) begin
               r_count  <= CW'(1);
               r_wr_ptr <= w_rd_next + AW'(1);
            end else begin
               r_count  <= '0;
               r_wr_ptr <= w_rd_next;
            end
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && w_push) begin
         r_mem_pc[r_wr_ptr]   <= in_pc;
         r_mem_inst[r_wr_ptr] <= in_inst;
      end
   end

   assign count = r_count;

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: hand-derived vector table for the directed scenarios,
// a queue scoreboard checking every cycle, then a random traffic phase.
module tb_id_inst_queue;

   localparam int DEPTH = 4;
`ifdef ID_INST_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_ready;
   logic        flush;
   logic        flush_keep;
   logic [2:0]  count;

   id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_ready(out_ready), .flush(flush), .flush_keep(flush_keep), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        fl;
      logic        fk;
      logic        chk;
      logic [2:0]  eCount;
      logic        eOv;
      logic        eIr;
      logic [31:0] ePc;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   bit          modelOk = 1'b0;
   int          nCompared = 0;
   int          nMismatched = 0;
   int          cyc = 0;

   function automatic logic [31:0] instOf(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction

   task automatic addVec(input logic r, input logic iv, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic fk,
                         input logic chk, input logic [2:0] eCount,
                         input logic eOv, input logic eIr, input logic [31:0] ePc);
      vec_t v;
      v.r = r; v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl; v.fk = fk;
      v.chk = chk; v.eCount = eCount; v.eOv = eOv; v.eIr = eIr; v.ePc = ePc;
      vecs.push_back(v);
   endtask

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Checks the current-cycle view against the scoreboard and the vector's own expectations.
   task automatic checkOutput(input vec_t v);
      logic        expOv;
      logic [63:0] expHead;
      int          n;
      n = sb.size();
      if (modelOk) begin
         expOv   = (n != 0) || (BYP && !v.fl && v.iv);
         expHead = (n != 0) ? sb[0] : {v.pc, instOf(v.pc)};
         compare("sb_count", 64'(count), 64'(n));
         compare("sb_out_valid", 64'(out_valid), 64'(expOv));
         compare("sb_in_ready", 64'(in_ready), 64'((n < DEPTH) || (n != 0 && v.ordy)));
         if (expOv && out_valid) begin
            compare("sb_head", {out_pc, out_inst}, expHead);
         end
      end
      if (v.chk) begin
         compare("vec_count", 64'(count), 64'(v.eCount));
         compare("vec_out_valid", 64'(out_valid), 64'(v.eOv));
         compare("vec_in_ready", 64'(in_ready), 64'(v.eIr));
         if (v.eOv) begin
            compare("vec_out_pc", 64'(out_pc), 64'(v.ePc));
         end
      end
   endtask

   task automatic modelStep(input vec_t v);
      int  n;
      bit  bypassTake;
      bit  pop;
      bit  push;
      bit  mIr;
      if (!v.r) begin
         sb.delete();
         modelOk = 1'b1;
         return;
      end
      n          = sb.size();
      bypassTake = BYP && n == 0 && !v.fl && v.iv && v.ordy;
      pop        = (n != 0) && v.ordy;
      mIr        = (n < DEPTH) || pop;
      push       = v.iv && mIr && !v.fl && !bypassTake;
      if (pop) void'(sb.pop_front());
      if (v.fl) begin
         if (v.fk && sb.size() != 0) begin
            while (sb.size() > 1) void'(sb.pop_back());
         end else begin
            sb.delete();
         end
      end else if (push) begin
         sb.push_back({v.pc, instOf(v.pc)});
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst        = v.r;
      in_valid   = v.iv;
      in_pc      = v.pc;
      in_inst    = instOf(v.pc);
      out_ready  = v.ordy;
      flush      = v.fl;
      flush_keep = v.fk;
      #4;
      checkOutput(v);
      modelStep(v);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      vec_t        v;
      logic [31:0] rpc;
      int          n;
      bit          willTake;

      rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0;

      //     r  iv pc      ordy fl fk chk cnt ov ir ePc
      addVec(0, 0, 32'h0,   0,  0, 0, 0,  0,  0, 1, 32'h0);
      addVec(0, 0, 32'h0,   0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h100, 0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h104, 0,  0, 0, 1,  1,  1, 1, 32'h100);
      addVec(1, 1, 32'h108, 0,  0, 0, 1,  2,  1, 1, 32'h100);
      addVec(1, 0, 32'h0,   0,  0, 0, 1,  3,  1, 1, 32'h100);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  3,  1, 1, 32'h100);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  2,  1, 1, 32'h104);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  1,  1, 1, 32'h108);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  0,  0, 1, 32'h0);
      // Fill to full, hold the fifth, then push+pop across the pointer wrap
      addVec(1, 1, 32'h400, 0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h404, 0,  0, 0, 1,  1,  1, 1, 32'h400);
      addVec(1, 1, 32'h408, 0,  0, 0, 1,  2,  1, 1, 32'h400);
      addVec(1, 1, 32'h40C, 0,  0, 0, 1,  3,  1, 1, 32'h400);
      addVec(1, 1, 32'h410, 0,  0, 0, 1,  4,  1, 0, 32'h400);
      addVec(1, 1, 32'h410, 0,  0, 0, 1,  4,  1, 0, 32'h400);
      addVec(1, 1, 32'h410, 1,  0, 0, 1,  4,  1, 1, 32'h400);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  4,  1, 1, 32'h404);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  3,  1, 1, 32'h408);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  2,  1, 1, 32'h40C);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  1,  1, 1, 32'h410);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  0,  0, 1, 32'h0);
      // Flush with keep: head popped, next entry kept, incoming push dropped
      addVec(1, 1, 32'h200, 0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h204, 0,  0, 0, 1,  1,  1, 1, 32'h200);
      addVec(1, 1, 32'h208, 0,  0, 0, 1,  2,  1, 1, 32'h200);
      addVec(1, 1, 32'h20C, 1,  1, 1, 1,  3,  1, 1, 32'h200);
      addVec(1, 0, 32'h0,   0,  0, 0, 1,  1,  1, 1, 32'h204);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  1,  1, 1, 32'h204);
      addVec(1, 0, 32'h0,   0,  0, 0, 1,  0,  0, 1, 32'h0);
      // Full flush, then keep-flush of an empty queue
      addVec(1, 1, 32'h500, 0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h504, 0,  0, 0, 1,  1,  1, 1, 32'h500);
      addVec(1, 1, 32'h508, 0,  0, 0, 1,  2,  1, 1, 32'h500);
      addVec(1, 0, 32'h0,   0,  1, 0, 1,  3,  1, 1, 32'h500);
      addVec(1, 0, 32'h0,   0,  1, 1, 1,  0,  0, 1, 32'h0);
      addVec(1, 0, 32'h0,   0,  0, 0, 1,  0,  0, 1, 32'h0);
      // Reset in the middle of traffic
      addVec(1, 1, 32'h600, 0,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 1, 32'h604, 0,  0, 0, 1,  1,  1, 1, 32'h600);
      addVec(1, 1, 32'h608, 0,  0, 0, 1,  2,  1, 1, 32'h600);
      addVec(0, 1, 32'h60C, 1,  0, 0, 1,  3,  1, 1, 32'h600);
      addVec(1, 0, 32'h0,   0,  0, 0, 1,  0,  0, 1, 32'h0);
      // Empty-queue latency, with and without the bypass path
`ifdef ID_INST_QUEUE_BYPASS_EN
      addVec(1, 1, 32'h700, 1,  0, 0, 1,  0,  1, 1, 32'h700);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  0,  0, 1, 32'h0);
`else
      addVec(1, 1, 32'h700, 1,  0, 0, 1,  0,  0, 1, 32'h0);
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  1,  1, 1, 32'h700);
`endif
      addVec(1, 0, 32'h0,   1,  0, 0, 1,  0,  0, 1, 32'h0);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Random traffic; IF keeps offering the same PC until it is taken or flushed away
      rpc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         v.r    = ($urandom_range(0, 63) != 0);
         v.iv   = ($urandom_range(0, 3) != 0);
         v.pc   = rpc;
         v.ordy = ($urandom_range(0, 2) != 0);
         v.fl   = ($urandom_range(0, 15) == 0);
         v.fk   = $urandom_range(0, 1) != 0;
         v.chk  = 1'b0;
         v.eCount = '0; v.eOv = 1'b0; v.eIr = 1'b0; v.ePc = '0;
         n = sb.size();
         willTake = v.iv && ((n < DEPTH) || (n != 0 && v.ordy));
         applyStimulus(v);
         if (willTake || v.fl || !v.r) rpc = rpc + 32'd4;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/id_inst_queue.md
ID_INST_QUEUE -- requirements
Module: id_inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter PC_W, default 32, PC field width.
REQ-003 Parameter INST_W, default 32, instruction field width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-006 in_valid  input  1  IF presents {in_pc, in_inst} this cycle.
REQ-007 in_pc  input  PC_W  PC of incoming instruction.
REQ-008 in_inst  input  INST_W  instruction word from instruction SRAM.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 out_valid  output  1  head entry presented to ID decode.
REQ-011 out_pc  output  PC_W  head PC.
REQ-012 out_inst  output  INST_W  head instruction.
REQ-013 out_ready  input  1  ID consumes head this cycle (low = ID stall).
REQ-014 flush  input  1  branch taken in ID; discard younger instructions.
REQ-015 flush_keep  input  1  with flush: retain one delay-slot entry.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage: circular buffer, DEPTH entries of {pc, inst}; wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-018 in_ready = (count < DEPTH) | (out_valid & out_ready) — push allowed when full if a pop occurs same cycle.
REQ-019 Push when in_valid & in_ready & ~flush; entry written at wr_ptr, wr_ptr+1.
REQ-020 Pop when out_valid & out_ready; rd_ptr+1.
REQ-021 out_valid = (count != 0); out_pc/out_inst = entry at rd_ptr; held stable while out_ready low.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 Push while full without pop: not accepted (in_ready=0); IF holds input; no entry overwritten.
REQ-024 Pop while empty: ignored; pointers and count unchanged.
REQ-025 Flush, flush_keep=0: after applying this cycle's pop, all entries discarded; count=0, wr_ptr=rd_ptr (post-pop); same-cycle push dropped.
REQ-026 Flush, flush_keep=1: after this cycle's pop, oldest remaining entry retained (count=1, wr_ptr=rd_ptr+1) if one exists, else count=0; same-cycle push dropped.
REQ-027 Latency: pushed entry visible on out_* next cycle (configured-out bypass).
REQ-028 Entry order strictly FIFO; no reordering, no duplication.

Reset
REQ-029 rst=0 at posedge clk: wr_ptr=0, rd_ptr=0, count=0; next cycle out_valid=0, in_ready=1, count=0.
REQ-030 Reset overrides push, pop and flush in the same cycle; storage contents need no reset.
REQ-031 out_pc/out_inst undefined while out_valid=0; bench checks them only when out_valid=1.

Configuration
REQ-032 Macro ID_INST_QUEUE_BYPASS_EN defined: when count=0 and ~flush, out_valid=in_valid and out_pc/out_inst=in_pc/in_inst combinationally; if out_ready also 1, instruction consumed with no write (zero latency); otherwise written as normal push.
REQ-033 Macro undefined: no combinational in-to-out path; REQ-027 latency of one cycle applies.

Verification
REQ-034 Reset then push PCs 0x100,0x104,0x108 with out_ready=0 -> count=3, out_pc=0x100 held 3 cycles; raise out_ready -> pops 0x100,0x104,0x108 in order.
REQ-035 DEPTH=4: push 5 with out_ready=0 -> in_ready=0 at count=4, 5th held; then out_ready=1 with in_valid=1 -> push+pop same cycle, count stays 4, pointers wrap past 3 to 0.
REQ-036 Queue holds 0x200,0x204,0x208; flush=1, flush_keep=1, out_ready=1, in_valid=1 (0x20C) -> 0x200 popped, count=1, next out_pc=0x204, 0x20C dropped.
REQ-037 Queue holds 3 entries; flush=1, flush_keep=0, out_ready=0 -> count=0, out_valid=0 next cycle; flush with count=0 and flush_keep=1 -> count stays 0.
REQ-038 Mid-operation rst=0 with count=3, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-039 Empty queue, in_valid=1 (0x300), out_ready=1: with ID_INST_QUEUE_BYPASS_EN -> out_valid=1, out_pc=0x300 same cycle, count stays 0; without -> out_valid=0 this cycle, out_pc=0x300 next cycle.
